// File: rtl/rocket_ctrl.sv
// rocket_ctrl: per-frame rocket movement and single-bullet sequencer.
// Frame tick from vsync, debounced buttons, bullet FSM.
`timescale 1ns/1ps
module rocket_ctrl #(
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 629,
  parameter int X_INIT      = 315,
  parameter int STEP        = 2,
  parameter int BULLET_STEP = 4,
  parameter int BULLET_Y0   = 452,
  parameter int BULLET_XOFF = 5,
  parameter int DEB_FRAMES  = 2,
  parameter int COOLDOWN    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_fire,
  input  logic       game_en,
  input  logic       bullet_hit,
  output logic       frame_tick,
  output logic [9:0] rocket_x,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_y,
  output logic       bullet_active,
  output logic [7:0] shot_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FLY  = 2'd1,
    S_COOL = 2'd2
  } state_t;

  localparam logic [2:0]  DEB    = 3'(DEB_FRAMES);
  localparam logic [10:0] XMIN11 = 11'(X_MIN);
  localparam logic [10:0] XMAX11 = 11'(X_MAX);
  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [9:0]  BSTEP  = 10'(BULLET_STEP);
  localparam logic [9:0]  BY0    = 10'(BULLET_Y0);
  localparam logic [9:0]  BXOFF  = 10'(BULLET_XOFF);
  localparam logic [7:0]  CD0    = 8'(COOLDOWN);

  // button bit order: {fire, right, left}
  logic       vs_s1, vs_s2, vs_prev;
  logic [2:0] btn_s1, btn_s2;

  logic [2:0][2:0] cnt_q, cnt_d;
  logic [2:0]      pressed;
  logic            step;
  logic            fire_edge;

  logic [10:0] x_wide, x_mv;
  logic [9:0]  x_new;

  state_t      state_q, state_d;
  logic [7:0]  cd_q, cd_d;
  logic [9:0]  bx_d, by_d;
  logic        act_d;
  logic [7:0]  shot_d;

  assign step = frame_tick & game_en;

  // Input synchronizers and falling-vsync frame tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_s1      <= 1'b0;
      vs_s2      <= 1'b0;
      vs_prev    <= 1'b0;
      frame_tick <= 1'b0;
      btn_s1     <= '0;
      btn_s2     <= '0;
    end else begin
      vs_s1      <= vsync;
      vs_s2      <= vs_s1;
      vs_prev    <= vs_s2;
      frame_tick <= vs_prev & ~vs_s2;
      btn_s1     <= {btn_fire, btn_right, btn_left};
      btn_s2     <= btn_s1;
    end
  end

  // Debounce counters: count high frame samples, saturate at DEB
  always_comb begin
    cnt_d = cnt_q;
    if (step) begin
      for (int i = 0; i < 3; i++) begin
        if (!btn_s2[i])
          cnt_d[i] = '0;
        else if (cnt_q[i] != DEB)
          cnt_d[i] = cnt_q[i] + 3'd1;
      end
    end
    for (int i = 0; i < 3; i++)
      pressed[i] = (cnt_d[i] == DEB);
    fire_edge = step & pressed[2] & (cnt_q[2] != DEB);
  end

  // Debounce counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // Clamped move, computed wide so it never wraps
  always_comb begin
    x_wide = {1'b0, rocket_x};
    x_mv   = x_wide;
    unique case (1'b1)
      (pressed[0] & ~pressed[1]):
        x_mv = (x_wide < XMIN11 + STEP11) ? XMIN11
                                          : x_wide - STEP11;
      (pressed[1] & ~pressed[0]):
        x_mv = (x_wide + STEP11 > XMAX11) ? XMAX11
                                          : x_wide + STEP11;
      default: x_mv = x_wide;
    endcase
    x_new = step ? x_mv[9:0] : rocket_x;
  end

  // Rocket position register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rocket_x <= 10'(X_INIT);
    else
      rocket_x <= x_new;
  end

  // Bullet FSM next state; hit wins over a same-cycle tick
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    bx_d    = bullet_x;
    by_d    = bullet_y;
    act_d   = bullet_active;
    shot_d  = shot_count;
    unique case (state_q)
      S_IDLE: begin
        if (fire_edge) begin
          state_d = S_FLY;
          bx_d    = x_new + BXOFF;
          by_d    = BY0;
          act_d   = 1'b1;
          if (shot_count != 8'hFF)
            shot_d = shot_count + 8'd1;
        end
      end
      S_FLY: begin
        if (bullet_hit || (step && bullet_y < BSTEP)) begin
          state_d = S_COOL;
          act_d   = 1'b0;
          cd_d    = CD0;
        end else if (step) begin
          by_d = bullet_y - BSTEP;
        end
      end
      S_COOL: begin
        if (step) begin
          if (cd_q == 8'd0)
            state_d = S_IDLE;
          else
            cd_d = cd_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bullet FSM and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cd_q          <= '0;
      bullet_x      <= '0;
      bullet_y      <= '0;
      bullet_active <= 1'b0;
      shot_count    <= '0;
    end else begin
      state_q       <= state_d;
      cd_q          <= cd_d;
      bullet_x      <= bx_d;
      bullet_y      <= by_d;
      bullet_active <= act_d;
      shot_count    <= shot_d;
    end
  end

endmodule

// File: tb/tb_rocket_ctrl.sv
// tb_rocket_ctrl: vector table, directed corner sequences and
// randomized frames checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_rocket_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       vsync;
  logic       btn_left, btn_right, btn_fire;
  logic       game_en, bullet_hit;
  logic       frame_tick;
  logic [9:0] rocket_x, bullet_x, bullet_y;
  logic       bullet_active;
  logic [7:0] shot_count;

  int errors = 0;
  int checks = 0;

  rocket_ctrl dut (
    .clk(clk), .reset(reset), .vsync(vsync),
    .btn_left(btn_left), .btn_right(btn_right),
    .btn_fire(btn_fire), .game_en(game_en),
    .bullet_hit(bullet_hit), .frame_tick(frame_tick),
    .rocket_x(rocket_x), .bullet_x(bullet_x),
    .bullet_y(bullet_y), .bullet_active(bullet_active),
    .shot_count(shot_count)
  );

  always #5 clk = ~clk;

  localparam int DEB = 2;
  localparam int CD  = 8;

  // reference model state
  bit mv1, mv2, mvp, mt;
  bit [2:0] mb1, mb2;
  int mcnt [3];
  int mx, my, mbx, mshot, mwait;
  bit mact;

  task automatic model_reset();
    mv1 = 0; mv2 = 0; mvp = 0; mt = 0;
    mb1 = 0; mb2 = 0;
    for (int i = 0; i < 3; i++) mcnt[i] = 0;
    mx = 315; my = 0; mbx = 0; mshot = 0;
    mwait = 0; mact = 0;
  endtask

  // advance the model across one rising edge
  task automatic model_step();
    bit tk, en, ht, oldf, fe, pl, pr, pf;
    bit [2:0] bn;
    tk = mt; en = game_en; ht = bullet_hit; bn = mb2;
    fe = 0;
    mt  = mvp & ~mv2;
    mvp = mv2; mv2 = mv1; mv1 = vsync;
    mb2 = mb1; mb1 = {btn_fire, btn_right, btn_left};
    if (tk && en) begin
      oldf = (mcnt[2] == DEB);
      for (int i = 0; i < 3; i++)
        mcnt[i] = bn[i] ? ((mcnt[i] + 1 > DEB) ? DEB : mcnt[i] + 1) : 0;
      pl = (mcnt[0] == DEB);
      pr = (mcnt[1] == DEB);
      pf = (mcnt[2] == DEB);
      fe = pf && !oldf;
      if (pl && !pr) mx = (mx - 2 < 0) ? 0 : mx - 2;
      else if (pr && !pl) mx = (mx + 2 > 629) ? 629 : mx + 2;
    end
    if (mact && ht) begin
      mact = 0; mwait = CD + 1;
    end else if (tk && en) begin
      if (mact) begin
        if (my < 4) begin mact = 0; mwait = CD + 1; end
        else my = my - 4;
      end else if (mwait > 0) begin
        mwait = mwait - 1;
      end else if (fe) begin
        mact = 1; mbx = mx + 5; my = 452;
        if (mshot < 255) mshot = mshot + 1;
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // per-cycle model comparison on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (reset) model_reset();
      else begin
        checks++;
        if (frame_tick !== mt || rocket_x !== 10'(mx) ||
            bullet_active !== mact || bullet_x !== 10'(mbx) ||
            bullet_y !== 10'(my) || shot_count !== 8'(mshot)) begin
          errors++;
          if (errors <= 20)
            $display("FAIL model t=%0t tick=%0b/%0b x=%0d/%0d act=%0b/%0b bx=%0d/%0d by=%0d/%0d shots=%0d/%0d",
              $time, frame_tick, mt, rocket_x, mx, bullet_active, mact,
              bullet_x, mbx, bullet_y, my, shot_count, mshot);
        end
        model_step();
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step(input int c);
    repeat (c) @(posedge clk);
    #2;
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      vsync = 1'b0; step(3);
      vsync = 1'b1; step(9);
    end
  endtask

  typedef struct {
    bit l, r, f, en;
    int frames;
    int x, by, bx;
    bit act;
    int shot;
  } vec_t;

  vec_t tbl [14];
  bit   found;
  int   len;

  initial begin
    tbl[0]  = '{0,0,0,1, 3, 315,  0,  0,0,0};
    tbl[1]  = '{1,1,0,1,10, 315,  0,  0,0,0};
    tbl[2]  = '{0,0,0,1, 1, 315,  0,  0,0,0};
    tbl[3]  = '{1,0,0,1, 1, 315,  0,  0,0,0};
    tbl[4]  = '{1,0,0,1, 1, 313,  0,  0,0,0};
    tbl[5]  = '{1,0,0,1, 5, 303,  0,  0,0,0};
    tbl[6]  = '{0,0,0,1, 1, 303,  0,  0,0,0};
    tbl[7]  = '{0,1,0,1, 4, 309,  0,  0,0,0};
    tbl[8]  = '{0,0,1,1, 1, 309,  0,  0,0,0};
    tbl[9]  = '{0,0,0,1, 1, 309,  0,  0,0,0};
    tbl[10] = '{0,0,1,1, 2, 309,452,314,1,1};
    tbl[11] = '{0,0,1,1, 3, 309,440,314,1,1};
    tbl[12] = '{0,0,1,0, 5, 309,440,314,1,1};
    tbl[13] = '{0,0,1,1, 1, 309,436,314,1,1};

    reset = 1'b1; vsync = 1'b1;
    btn_left = 0; btn_right = 0; btn_fire = 0;
    game_en = 1; bullet_hit = 0;
    step(3);
    chk("rst_x", rocket_x, 315);
    chk("rst_act", bullet_active, 0);
    chk("rst_shot", shot_count, 0);
    chk("rst_tick", frame_tick, 0);
    reset = 1'b0;
    step(5);

    vsync = 1'b0;
    step(2); chk("tick_e2", frame_tick, 0);
    step(1); chk("tick_e3", frame_tick, 1);
    step(1); chk("tick_e4", frame_tick, 0);
    vsync = 1'b1; step(9);

    for (int i = 0; i < 14; i++) begin
      btn_left = tbl[i].l; btn_right = tbl[i].r;
      btn_fire = tbl[i].f; game_en = tbl[i].en;
      frames(tbl[i].frames);
      chk($sformatf("row%0d_x", i), rocket_x, tbl[i].x);
      chk($sformatf("row%0d_by", i), bullet_y, tbl[i].by);
      chk($sformatf("row%0d_bx", i), bullet_x, tbl[i].bx);
      chk($sformatf("row%0d_act", i), bullet_active, tbl[i].act);
      chk($sformatf("row%0d_shot", i), shot_count, tbl[i].shot);
    end

    for (int k = 0; k < 100 && my != 200; k++) frames(1);
    chk("reach200", bullet_y, 200);
    vsync = 1'b0; found = 0;
    for (int c = 0; c < 8 && !found; c++) begin
      step(1);
      if (frame_tick) found = 1;
    end
    chk("tick_seen", found, 1);
    bullet_hit = 1; step(1); bullet_hit = 0;
    chk("hit_act", bullet_active, 0);
    chk("hit_y", bullet_y, 200);
    vsync = 1'b1; step(9);

    btn_fire = 0; frames(1);
    btn_fire = 1; frames(2);
    chk("cool_fire_shot", shot_count, 1);
    chk("cool_fire_act", bullet_active, 0);
    frames(10);
    chk("held_shot", shot_count, 1);
    btn_fire = 0; frames(1);
    btn_fire = 1; frames(2);
    chk("refire_shot", shot_count, 2);
    chk("refire_act", bullet_active, 1);
    chk("refire_y", bullet_y, 452);

    #1 reset = 1'b1;
    #1;
    chk("amid_x", rocket_x, 315);
    chk("amid_act", bullet_active, 0);
    chk("amid_shot", shot_count, 0);
    chk("amid_by", bullet_y, 0);
    chk("amid_bx", bullet_x, 0);
    btn_fire = 0;
    step(1);
    reset = 1'b0;
    step(2);

    btn_left = 1; frames(200);
    chk("clamp_lo", rocket_x, 0);
    btn_left = 0; btn_right = 1; frames(400);
    chk("clamp_hi", rocket_x, 629);
    btn_right = 0; frames(1);

    for (int i = 0; i < 257; i++) begin
      btn_fire = 1; frames(2);
      if (i == 0) chk("sat_first_act", bullet_active, 1);
      bullet_hit = 1; step(1); bullet_hit = 0;
      btn_fire = 0; frames(8);
      if (i == 254) chk("shot_255", shot_count, 255);
    end
    chk("shot_sat", shot_count, 255);

    btn_fire = 1; frames(2);
    chk("end_launch_bx", bullet_x, 634);
    chk("end_launch_y", bullet_y, 452);
    frames(112);
    chk("end_y4", bullet_y, 4);
    chk("end_act1", bullet_active, 1);
    frames(2);
    chk("end_act0", bullet_active, 0);
    chk("end_y0", bullet_y, 0);
    chk("end_shot", shot_count, 255);
    btn_fire = 0;

    for (int f = 0; f < 300; f++) begin
      if ($urandom_range(0, 3) == 0) btn_left  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) btn_right = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) btn_fire  = 1'($urandom_range(0, 1));
      game_en = ($urandom_range(0, 7) != 0);
      len = 12 + int'($urandom_range(0, 4));
      vsync = 1'b0;
      for (int c = 0; c < len; c++) begin
        bullet_hit = ($urandom_range(0, 39) == 0);
        if (c == 3) vsync = 1'b1;
        step(1);
      end
      bullet_hit = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
